// File: rtl/xnor_conv_sequencer.sv
// Start/busy/done sequencer around the XNOR conv accelerator: streams scratchpad rows in and writes packed results back.
// Optional per-lane running sums on acc_out when XNOR_SEQ_ACCUM_EN is defined.
module xnor_conv_sequencer #(
  parameter int unsigned NUMHELPER       = 4,
  parameter int unsigned INPUT_BITWIDTH  = 25,
  parameter int unsigned OUTPUT_BITWIDTH = 6,
  parameter int unsigned SIZE            = 16,
  parameter int unsigned PIPE_LATENCY    = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [$clog2(SIZE):0]                 length,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_on,
  output logic [$clog2(SIZE)-1:0]               rd_addr,
  output logic                                  pe_reset,
  input  logic [NUMHELPER*OUTPUT_BITWIDTH-1:0]  pe_out_c,
  output logic                                  wr_on,
  output logic                                  wr_en,
  output logic [$clog2(SIZE)-1:0]               wr_addr,
  output logic [NUMHELPER*INPUT_BITWIDTH-1:0]   wr_data
`ifdef XNOR_SEQ_ACCUM_EN
  ,
  output logic [NUMHELPER*16-1:0]               acc_out
`endif
);

  localparam int unsigned AW  = $clog2(SIZE);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned EXT = INPUT_BITWIDTH - OUTPUT_BITWIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                              state;
  logic [LW-1:0]                       len_q;
  logic [LW-1:0]                       len_clamped;
  logic                                last_issue;
  logic                                pipe_empty;
  logic                                tag_exit;
  logic [PIPE_LATENCY-1:0]             tag_v;
  logic [AW-1:0]                       tag_a [PIPE_LATENCY];
  logic [NUMHELPER*INPUT_BITWIDTH-1:0] cap_data;

  always_comb begin
    len_clamped = (length > LW'(SIZE)) ? LW'(SIZE) : length;
    last_issue  = (LW'(rd_addr) == (len_q - LW'(1)));
    pipe_empty  = ~|tag_v;
    tag_exit    = tag_v[PIPE_LATENCY-1];
  end

  // Sign-extend each accelerator lane into the scratchpad lane width.
  always_comb begin
    cap_data = '0;
    for (int j = 0; j < NUMHELPER; j++) begin
      cap_data[j*INPUT_BITWIDTH +: INPUT_BITWIDTH] =
        {{EXT{pe_out_c[j*OUTPUT_BITWIDTH + OUTPUT_BITWIDTH - 1]}},
         pe_out_c[j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      tag_v    <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) tag_a[i] <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_on    <= 1'b0;
      rd_addr  <= '0;
      pe_reset <= 1'b1;
      wr_on    <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      // Tag pipe mirrors the scratchpad + PE latency of each issued row.
      tag_v[0] <= rd_on;
      tag_a[0] <= rd_addr;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end

      wr_on <= tag_exit;
      wr_en <= tag_exit;
      if (tag_exit) begin
        wr_addr <= tag_a[PIPE_LATENCY-1];
        wr_data <= cap_data;
      end

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            pe_reset <= 1'b0;
            len_q    <= len_clamped;
            if (len_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= READ;
              rd_on   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        READ: begin
          if (last_issue) begin
            state <= DRAIN;
            rd_on <= 1'b0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        DRAIN: begin
          // Empty pipe means any pending write is in its final cycle now.
          if (pipe_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          pe_reset <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XNOR_SEQ_ACCUM_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [OUTPUT_BITWIDTH-1:0] b);
    logic signed [16:0] s;
    s = $signed({a[15], a}) +
        $signed({{(17-OUTPUT_BITWIDTH){b[OUTPUT_BITWIDTH-1]}}, b});
    if (s > 17'sd32767)       return 16'h7FFF;
    else if (s < -17'sd32767) return 16'h8001;
    else                      return s[15:0];
  endfunction

  // Per-lane running sums, cleared when a run is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_out <= '0;
    end else if (state == IDLE && start) begin
      acc_out <= '0;
    end else if (tag_exit) begin
      for (int j = 0; j < NUMHELPER; j++) begin
        acc_out[j*16 +: 16] <= sat_add(acc_out[j*16 +: 16],
                                       pe_out_c[j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_xnor_conv_sequencer.sv
// Scoreboard bench for xnor_conv_sequencer with scratchpad/accelerator models around it.
module tb_xnor_conv_sequencer;

  localparam int NH  = 4;
  localparam int IBW = 25;
  localparam int OBW = 6;
  localparam int SZ  = 16;
  localparam int RW  = NH*IBW;
  localparam int OW  = NH*OBW;

  typedef struct {
    logic [3:0]    addr;
    logic [RW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    length;
  logic          busy, done, rd_on, pe_reset, wr_on, wr_en;
  logic [3:0]    rd_addr, wr_addr;
  logic [OW-1:0] pe_out;
  logic [RW-1:0] wr_data;
`ifdef XNOR_SEQ_ACCUM_EN
  logic [NH*16-1:0] acc_out;
`endif

  logic [RW-1:0] in_mem [SZ];
  logic [RW-1:0] w_mem  [SZ];
  logic [RW-1:0] out_mem[SZ];
  logic [RW-1:0] exp_mem[SZ];
  logic [RW-1:0] rd_in, rd_w;
  exp_t          exp_q[$];
  int            acc_exp[NH];

  int total = 0;
  int bad   = 0;

  xnor_conv_sequencer dut (
    .clock(clk), .reset(reset), .start(start), .length(length),
    .busy(busy), .done(done), .rd_on(rd_on), .rd_addr(rd_addr),
    .pe_reset(pe_reset), .pe_out_c(pe_out), .wr_on(wr_on), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef XNOR_SEQ_ACCUM_EN
    , .acc_out(acc_out)
`endif
  );

  always #5 clk = ~clk;

  // Accelerator lane = 2*popcount(xnor) - width.
  function automatic logic [OW-1:0] pe_model(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [OW-1:0]  r;
    logic [IBW-1:0] x;
    int             pop;
    r = '0;
    for (int j = 0; j < NH; j++) begin
      x   = ~(a[j*IBW +: IBW] ^ b[j*IBW +: IBW]);
      pop = $countones(x);
      r[j*OBW +: OBW] = OBW'(2*pop - IBW);
    end
    return r;
  endfunction

  function automatic int ref_lane(input logic [RW-1:0] a, input logic [RW-1:0] b, input int j);
    int s;
    s = 0;
    for (int k = 0; k < IBW; k++) s += (a[j*IBW+k] == b[j*IBW+k]) ? 1 : -1;
    return s;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  // Scratchpads (registered read), accelerator and output scratchpad.
  always @(posedge clk) begin
    if (rd_on) begin
      rd_in <= in_mem[rd_addr];
      rd_w  <= w_mem[rd_addr];
    end
    if (pe_reset) pe_out <= '0;
    else          pe_out <= pe_model(rd_in, rd_w);
    if (wr_on && wr_en) out_mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected write", 128'(wr_addr), 128'(1000));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 128'(wr_addr), 128'(e.addr));
        chk("wr_data", 128'(wr_data), 128'(e.data));
      end
    end
  end

  task automatic fill_random();
    for (int k = 0; k < SZ; k++) begin
      in_mem[k] = RW'({$urandom, $urandom, $urandom, $urandom});
      w_mem[k]  = RW'({$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  task automatic run(input int len, input bit poke);
    int le, dc;
    logic [RW-1:0] row;
    le = (len > SZ) ? SZ : len;
    dc = (le == 0) ? 1 : le + 4;
    @(negedge clk);
    for (int j = 0; j < NH; j++) acc_exp[j] = 0;
    for (int k = 0; k < le; k++) begin
      row = '0;
      for (int j = 0; j < NH; j++) begin
        row[j*IBW +: IBW] = IBW'(ref_lane(in_mem[k], w_mem[k], j));
        acc_exp[j] = sat16(acc_exp[j] + ref_lane(in_mem[k], w_mem[k], j));
      end
      exp_q.push_back('{addr: 4'(k), data: row});
      exp_mem[k] = row;
    end
    length = 5'(len);
    start  = 1'b1;
    for (int c = 1; c <= dc + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("rd_on", 128'(rd_on), 128'(c <= le));
      if (c <= le) chk("rd_addr", 128'(rd_addr), 128'(c - 1));
      chk("wr_en", 128'(wr_en), 128'(le > 0 && c >= 4 && c <= le + 3));
      chk("wr_on", 128'(wr_on), 128'(le > 0 && c >= 4 && c <= le + 3));
      chk("done", 128'(done), 128'(c == dc));
      chk("busy", 128'(busy), 128'(c <= dc));
      chk("pe_reset", 128'(pe_reset), 128'(c > dc));
`ifdef XNOR_SEQ_ACCUM_EN
      if (c == 1) chk("acc_clear", 128'(acc_out), 128'(0));
      if (c == dc)
        for (int j = 0; j < NH; j++)
          chk("acc_lane", 128'(acc_out[j*16 +: 16]), 128'(16'(acc_exp[j])));
`endif
      if (poke && c == 2) begin
        start  = 1'b1;
        length = 5'(3);
      end
    end
    start = 1'b0;
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    for (int k = 0; k < le; k++) chk("out_row", 128'(out_mem[k]), 128'(exp_mem[k]));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    length = '0;
    for (int k = 0; k < SZ; k++) begin
      in_mem[k]  = '0;
      w_mem[k]   = '0;
      out_mem[k] = '0;
    end
    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_rd_on", 128'(rd_on), 128'(0));
    chk("rst_wr_en", 128'(wr_en), 128'(0));
    chk("rst_pe_reset", 128'(pe_reset), 128'(1));
    @(negedge clk);
    reset = 1'b0;

    // All ones x all ones: every lane +25.
    for (int k = 0; k < SZ; k++) begin
      in_mem[k] = '1;
      w_mem[k]  = '1;
    end
    run(3, 1'b0);
    chk("s1_lane0", 128'(out_mem[0][24:0]), 128'(25'h0000019));
    chk("s1_lane3", 128'(out_mem[2][99:75]), 128'(25'h0000019));
`ifdef XNOR_SEQ_ACCUM_EN
    chk("s1_acc", 128'(acc_out[15:0]), 128'(16'd75));
`endif

    // All ones x all zeros: every lane -25.
    for (int k = 0; k < SZ; k++) w_mem[k] = '0;
    run(2, 1'b0);
    chk("s2_row0", 128'(out_mem[0][99:75]), 128'(25'h1FFFFE7));
    chk("s2_row1", 128'(out_mem[1][24:0]), 128'(25'h1FFFFE7));

    fill_random();
    run(16, 1'b1);
    run(0, 1'b0);
    fill_random();
    run(20, 1'b0);

    // Reset in cycle 3 of a length-8 run aborts it.
    fill_random();
    @(negedge clk);
    length = 5'd8;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rd_on", 128'(rd_on), 128'(0));
    chk("abort_rd_addr", 128'(rd_addr), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_wr", 128'({wr_on, wr_en, wr_addr}), 128'(0));
    chk("abort_wr_data", 128'(wr_data), 128'(0));
    chk("abort_pe_reset", 128'(pe_reset), 128'(1));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_no_done", 128'({done, wr_en}), 128'(0));
    end
    run(1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int len;
      fill_random();
      len = int'($urandom_range(1, 16));
      run(len, len >= 2);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
